// File: rtl/seg7_scan_display_if.sv
// Bus bundle for seg7_scan_display.
//   count[3:0], dir, running : counter status, asynchronous to clk
//   blank                    : synchronous blanking request
//   an[3:0]                  : digit anodes, active-low
//   seg[6:0]                 : segments {g,f,e,d,c,b,a}, active-low
//   dp                       : decimal point, active-low
// master = status source / display consumer, slave = the scan controller.
interface seg7_scan_display_if;
  logic [3:0] count;
  logic       dir;
  logic       running;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output count, dir, running, blank, input an, seg, dp);
  modport slave  (input count, dir, running, blank, output an, seg, dp);
endinterface

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed 7-segment driver for a 4-bit up/down counter.
// Digit 0: count mod 10, digit 1: tens (blank below 10), digit 2: U/d for
// direction, digit 3: '-' when stopped. Each slot opens with GUARD blank
// cycles to kill ghosting; dp on digit 0 blinks with a frame heartbeat.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : seg7_scan_display_if.slave (status inputs, an/seg/dp outputs)
module seg7_scan_display #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_scan_display_if.slave    bus
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);

  // {running, dir, count} pipeline: two sync stages, filter compare, display
  logic [5:0]    sync1_q, sync1_d;
  logic [5:0]    sync2_q, sync2_d;
  logic [5:0]    prev_q,  prev_d;
  logic [5:0]    disp_q,  disp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q,   idx_d;
  logic [5:0]    frame_q, frame_d;
  logic [3:0]    an_q,    an_d;
  logic [6:0]    seg_q,   seg_d;
  logic          dp_q,    dp_d;

  logic          wrap;
  logic          active;
  logic [3:0]    units;
  logic          tens_on;
  logic [6:0]    glyph;

  // Active-high digit glyphs {g..a}
  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    g = 7'h00;
    case (d)
      4'd0: g = 7'h3F;
      4'd1: g = 7'h06;
      4'd2: g = 7'h5B;
      4'd3: g = 7'h4F;
      4'd4: g = 7'h66;
      4'd5: g = 7'h6D;
      4'd6: g = 7'h7D;
      4'd7: g = 7'h07;
      4'd8: g = 7'h7F;
      4'd9: g = 7'h6F;
      default: g = 7'h00;
    endcase
    return g;
  endfunction

  // Next-state and output decode
  always_comb begin
    sync1_d = {bus.running, bus.dir, bus.count};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    // Load only a value seen on two consecutive cycles; otherwise hold
    disp_d  = (sync2_q == prev_q) ? sync2_q : disp_q;

    wrap    = (presc_q == PW'(REFRESH_DIV - 1));
    presc_d = wrap ? '0 : presc_q + PW'(1);
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    frame_d = (wrap && (idx_q == 2'd3) && disp_q[5]) ? frame_q + 6'd1 : frame_q;

    tens_on = (disp_q[3:0] >= 4'd10);
    units   = tens_on ? disp_q[3:0] - 4'd10 : disp_q[3:0];
    case (idx_q)
      2'd0:    glyph = digit_glyph(units);
      2'd1:    glyph = tens_on ? 7'h06 : 7'h00;
      2'd2:    glyph = disp_q[4] ? 7'h5E : 7'h3E;
      default: glyph = disp_q[5] ? 7'h00 : 7'h40;
    endcase

    active = (presc_q >= PW'(GUARD)) && !bus.blank;
    an_d   = 4'hF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (active) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = ~glyph;
      dp_d  = !((idx_q == 2'd0) && frame_q[5]);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      disp_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      frame_q <= '0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      disp_q  <= disp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 Parameter REFRESH_DIV, 100000, clk cycles per digit slot; legal range 8..2^20.
REQ-002 Parameter GUARD, 4, anti-ghost blanking cycles at the start of each slot; legal range 1..REFRESH_DIV-4.
REQ-003 clk  input  1  system clock; all state is clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 count  input  4  counter value, asynchronous to clk (comes from the divided counter clock).
REQ-006 dir  input  1  count direction, asynchronous: 0 = up, 1 = down.
REQ-007 running  input  1  run status, asynchronous: 1 = counting, 0 = stopped.
REQ-008 blank  input  1  synchronous to clk; 1 forces all digits off.
REQ-009 an  output  4  digit anodes, active-low, one-hot-low or all-high.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 dp  output  1  decimal point, active-low.

Function
REQ-012 count, dir and running shall each pass through a 2-flop synchronizer in the clk domain.
REQ-013 Stability filter: the 6-bit synchronized vector {running,dir,count} shall load the display register only after it has been equal on 2 consecutive clk cycles; otherwise the display register holds.
REQ-014 Latency: an input held steady shall reach the display register no later than 4 clk cycles after the input changes.
REQ-015 Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0; at the wrap, the digit index shall advance 0->1->2->3->0.
REQ-016 Digit 0 (an[0]) shall show count mod 10; digit 1 shall show the tens digit, 1 for count 10..15, and shall be blank for count 0..9.
REQ-017 Digit 2 shall show 'U' when dir=0 and 'd' when dir=1.
REQ-018 Digit 3 shall be blank when running=1 and shall show '-' when running=0.
REQ-019 Active-high glyph codes {g..a}, inverted on seg:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - U=3E, d=5E, '-'=40, blank=00
REQ-020 Anti-ghost: for prescaler values 0..GUARD-1, an shall be 4'hF, seg 7'h7F and dp 1; for the remainder of the slot, an[index] shall be 0 and all other anodes 1.
REQ-021 Frame counter: 6 bits; it shall increment when the index wraps 3->0 while running=1 and hold while running=0. Heartbeat shall be bit 5 of the frame counter.
REQ-022 dp shall be 0 only during the active portion of slot 0 while heartbeat=1; otherwise dp shall be 1.
REQ-023 blank=1 shall force an=4'hF from the next clk edge; prescaler, index and frame counter shall keep running; release takes effect on the next edge.
REQ-024 an, seg and dp shall be registered outputs, one cycle after the index/prescaler state that selects them.
REQ-025 Glyph data shall be sampled from the display register as it stands when the output register loads; a display update mid-slot shall change seg on the next cycle, with no extra blanking.
REQ-026 an shall never have more than one bit at 0 in any cycle.

Reset
REQ-027 While reset=1:
  - an=4'hF, seg=7'h7F, dp=1
  - prescaler=0, index=0, frame counter=0
  - synchronizers, filter and display register = 0
REQ-028 After reset deasserts, the first active anode shall be an[0], at prescaler=GUARD+1 cycles counting from the first clk edge.
REQ-029 Reset asserted mid-slot shall return all outputs to their reset values immediately, without waiting for a clk edge.

Verification (REFRESH_DIV=8, GUARD=2)
REQ-030 Reset release, inputs count=0, dir=0, running=1: an cycles 1110,1101,1011,0111, each low for 6 of every 8 clks and 1111 for 2. seg values in order: 0->40, digit1->7F, U->41, digit3->7F.
REQ-031 count=13, dir=1, running=0 applied together: within 4 clks the display shows digit0 seg=30 ('3'), digit1 seg=79 ('1'), digit2 seg=21 ('d'), digit3 seg=3F ('-').
REQ-032 count toggled every clk between 5 and 6 for 20 clks, then held at 7: the display register never captures a value other than the prior value or 7; digit0 ends as seg=78.
REQ-033 running=1 for 32 frames (1024 clks): dp=0 in slot 0 during frames 32..63; with running=0, dp stays at its current level and the frame counter is frozen.
REQ-034 blank=1 for 50 clks mid-slot: an=1111 throughout; after release, index is consistent with 50 elapsed clks (no scan stall).
REQ-035 Assert reset for 1 clk mid-slot 2: an, seg and dp go to their reset values asynchronously; the scan restarts at slot 0.
